// File: rtl/mult_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, default latencies
// and op-class helpers used by both the datapath and the control.
package mult_div_unit_pkg;

  localparam int WIDTH_MDOP    = 4;
  localparam int DEF_MULT_LAT  = 5;
  localparam int DEF_DIV_LAT   = 10;

  typedef enum logic [WIDTH_MDOP-1:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MADD  = 4'd5,
    MD_MADDU = 4'd6,
    MD_MSUB  = 4'd7,
    MD_MSUBU = 4'd8,
    MD_MTHI  = 4'd9,
    MD_MTLO  = 4'd10
  } md_op_e;

  // Arithmetic ops are the ones that go through the pending/countdown path.
  function automatic logic md_is_arith(input logic [WIDTH_MDOP-1:0] op);
    return (op >= MD_MULT) && (op <= MD_MSUBU);
  endfunction

  function automatic logic md_is_div(input logic [WIDTH_MDOP-1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mult_div_unit_compute.sv
// Combinational datapath: produces the full 64-bit {HI,LO} result for an
// arithmetic op from the operands and the current HI/LO.
module md_compute
  import mult_div_unit_pkg::*;
(
  input  logic [WIDTH_MDOP-1:0] i_md_op,
  input  logic [31:0]           i_rs_val,
  input  logic [31:0]           i_rt_val,
  input  logic [31:0]           i_hi,
  input  logic [31:0]           i_lo,
  output logic [63:0]           o_result,
  output logic                  o_div_by_zero
);

  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [63:0] w_acc;
  logic        w_signed_div;
  logic        w_neg_a;
  logic        w_neg_b;
  logic [31:0] w_num;
  logic [31:0] w_den;
  logic [31:0] w_q_u;
  logic [31:0] w_r_u;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  // Sign-extending to 64 bits first makes the truncated product the exact signed result.
  assign w_prod_s = {{32{i_rs_val[31]}}, i_rs_val} * {{32{i_rt_val[31]}}, i_rt_val};
  assign w_prod_u = {32'b0, i_rs_val} * {32'b0, i_rt_val};
  assign w_acc    = {i_hi, i_lo};

  // One unsigned divider serves both DIV and DIVU; signed divide works on magnitudes.
  assign w_signed_div = (i_md_op == MD_DIV);
  assign w_neg_a      = w_signed_div & i_rs_val[31];
  assign w_neg_b      = w_signed_div & i_rt_val[31];
  assign w_num        = w_neg_a ? (32'd0 - i_rs_val) : i_rs_val;
  assign w_den        = (i_rt_val == 32'd0) ? 32'd1
                      : (w_neg_b ? (32'd0 - i_rt_val) : i_rt_val);
  assign w_q_u        = w_num / w_den;
  assign w_r_u        = w_num % w_den;
  assign w_quot       = (w_neg_a ^ w_neg_b) ? (32'd0 - w_q_u) : w_q_u;
  assign w_rem        = w_neg_a ? (32'd0 - w_r_u) : w_r_u;

  assign o_div_by_zero = md_is_div(i_md_op) & (i_rt_val == 32'd0);

  always_comb begin
    o_result = 64'd0;
    case (i_md_op)
      MD_MULT:  o_result = w_prod_s;
      MD_MULTU: o_result = w_prod_u;
      MD_MADD:  o_result = w_acc + w_prod_s;
      MD_MADDU: o_result = w_acc + w_prod_u;
      MD_MSUB:  o_result = w_acc - w_prod_s;
      MD_MSUBU: o_result = w_acc - w_prod_u;
      MD_DIV,
      MD_DIVU:  o_result = {w_rem, w_quot};
      default:  o_result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multiply/divide unit: owns HI/LO, holds an arithmetic result pending for a
// fixed latency and commits it when the countdown expires.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [WIDTH_MDOP-1:0] i_md_op,
  input  logic                  i_start,
  input  logic [31:0]           i_rs_val,
  input  logic [31:0]           i_rt_val,
  input  logic                  i_dis,
  output logic                  o_busy,
  output logic [31:0]           o_hi,
  output logic [31:0]           o_lo
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] r_cnt;
  logic [63:0]      r_pend;
  logic             r_pend_dz;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;

  logic [63:0]      w_result;
  logic             w_div_by_zero;
  logic             w_req;
  logic             w_accept;
  logic             w_is_arith;

  md_compute u_compute (
    .i_md_op       (i_md_op),
    .i_rs_val      (i_rs_val),
    .i_rt_val      (i_rt_val),
    .i_hi          (r_hi),
    .i_lo          (r_lo),
    .o_result      (w_result),
    .o_div_by_zero (w_div_by_zero)
  );

  assign w_req      = i_start & ~i_dis;
  assign w_is_arith = md_is_arith(i_md_op);
  assign w_accept   = w_req & (i_md_op != MD_NONE) & (r_cnt == '0);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt     <= '0;
      r_pend    <= '0;
      r_pend_dz <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
      if ((r_cnt == CNT_W'(1)) && !r_pend_dz) begin
        r_hi <= r_pend[63:32];
        r_lo <= r_pend[31:0];
      end
    end else if (w_accept) begin
      if (i_md_op == MD_MTHI) begin
        r_hi <= i_rs_val;
      end else if (i_md_op == MD_MTLO) begin
        r_lo <= i_rs_val;
      end else if (w_is_arith) begin
        r_pend    <= w_result;
        r_pend_dz <= w_div_by_zero;
        r_cnt     <= md_is_div(i_md_op) ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
      end
    end
  end

  // The issue cycle reports busy combinationally so ID stalls without a bubble.
  assign o_busy = (r_cnt != '0) | (w_req & w_is_arith);
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
